// File: rtl/fifo_wr.sv
// fifo_wr: writes one incrementing burst into a FIFO each time its read side reports empty.
// Define FIFO_WR_STAT_EN to build the burst_cnt statistics port and counter.
module fifo_wr #(
  parameter logic [7:0] DATA_START    = 8'd0,
  parameter logic [3:0] SETTLE_CYCLES = 4'd10
) (
  input  logic        wr_clk,
  input  logic        sys_rst_n,
  input  logic        wr_rst_busy,
  input  logic        empty,
  input  logic        almost_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
`ifdef FIFO_WR_STAT_EN
  output logic [15:0] burst_cnt,
`endif
  output logic [1:0]  fsm_state
);

  // Handshake: fifo_wr_en is a valid with no ready; every cycle it is high is one write of
  // fifo_wr_data. almost_full is the only back-pressure: the write at which it is sampled
  // still completes, and fifo_wr_en drops from the following cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic       wr_en_nxt;
  logic [7:0] wr_data_nxt;
  logic       empty_d0, empty_d1;
  // Set after each completed burst; cleared once empty_d1 is seen low, so a stale empty
  // left over from the previous burst cannot start another one.
  logic       stale_lock, stale_lock_nxt;

  assign fsm_state = state;

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    wr_en_nxt      = fifo_wr_en;
    wr_data_nxt    = fifo_wr_data;
    stale_lock_nxt = stale_lock;

    if (fifo_wr_en) wr_data_nxt = fifo_wr_data + 8'd1;
    if (!empty_d1)  stale_lock_nxt = 1'b0;

    case (state)
      IDLE: begin
        wr_en_nxt = 1'b0;
        if (empty_d1 && !stale_lock) begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = 4'd0;
        end
      end
      SETTLE: begin
        settle_cnt_nxt = settle_cnt + 4'd1;
        if (settle_cnt == SETTLE_CYCLES - 4'd1) begin
          state_nxt      = WRITE;
          settle_cnt_nxt = 4'd0;
          wr_en_nxt      = 1'b1;
        end
      end
      WRITE: begin
        wr_en_nxt = 1'b1;
        if (almost_full && fifo_wr_en) begin
          wr_en_nxt = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        wr_en_nxt      = 1'b0;
        state_nxt      = IDLE;
        wr_data_nxt    = DATA_START;
        stale_lock_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Write-side reset of the FIFO overrides everything, including a pending almost_full.
    if (wr_rst_busy) begin
      state_nxt      = IDLE;
      settle_cnt_nxt = 4'd0;
      wr_en_nxt      = 1'b0;
      wr_data_nxt    = DATA_START;
    end
  end

  always_ff @(posedge wr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      settle_cnt   <= 4'd0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= DATA_START;
      empty_d0     <= 1'b0;
      empty_d1     <= 1'b0;
      stale_lock   <= 1'b0;
    end else begin
      state        <= state_nxt;
      settle_cnt   <= settle_cnt_nxt;
      fifo_wr_en   <= wr_en_nxt;
      fifo_wr_data <= wr_data_nxt;
      empty_d0     <= empty;
      empty_d1     <= empty_d0;
      stale_lock   <= stale_lock_nxt;
    end
  end

`ifdef FIFO_WR_STAT_EN
  logic burst_done;

  assign burst_done = (state == WRITE) && almost_full && fifo_wr_en && !wr_rst_busy;

  always_ff @(posedge wr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      burst_cnt <= 16'd0;
    end else if (burst_done && (burst_cnt != 16'hFFFF)) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr.sv
// tb_fifo_wr: directed bench for fifo_wr with a FIFO occupancy model and write-data scoreboard.
// Exercises burst_cnt as well when FIFO_WR_STAT_EN is defined.
module tb_fifo_wr;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd3;

  // ---------------- clock / reset / signals ----------------
  logic       wr_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       wr_rst_busy = 1'b0;
  logic       empty, almost_full;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic [1:0] fsm_state;
  logic       empty2 = 1'b0;
  logic       almost_full2;
  logic       f0_wr_en;
  logic [7:0] f0_wr_data;
  logic [1:0] f0_state;
`ifdef FIFO_WR_STAT_EN
  logic [15:0] burst_cnt, f0_burst_cnt;
`endif

  int   fifo_count = 0;
  int   af_at = 1000;
  int   cnt2 = 0;
  logic drain = 1'b0;
  logic empty_ovr_en = 1'b1;
  logic empty_ovr = 1'b0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_total = 0;
  int   exp_bursts = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  always #5 wr_clk = ~wr_clk;

  fifo_wr dut (
    .wr_clk       (wr_clk),
    .sys_rst_n    (sys_rst_n),
    .wr_rst_busy  (wr_rst_busy),
    .empty        (empty),
    .almost_full  (almost_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
`ifdef FIFO_WR_STAT_EN
    .burst_cnt    (burst_cnt),
`endif
    .fsm_state    (fsm_state)
  );

  fifo_wr #(.DATA_START(8'hF0), .SETTLE_CYCLES(4'd3)) dut_f0 (
    .wr_clk       (wr_clk),
    .sys_rst_n    (sys_rst_n),
    .wr_rst_busy  (wr_rst_busy),
    .empty        (empty2),
    .almost_full  (almost_full2),
    .fifo_wr_en   (f0_wr_en),
    .fifo_wr_data (f0_wr_data),
`ifdef FIFO_WR_STAT_EN
    .burst_cnt    (f0_burst_cnt),
`endif
    .fsm_state    (f0_state)
  );

  // ---------------- FIFO models ----------------
  assign empty        = empty_ovr_en ? empty_ovr : (fifo_count == 0);
  assign almost_full  = (fifo_count >= af_at);
  assign almost_full2 = (cnt2 >= 19);

  always @(posedge wr_clk) begin
    if (drain) fifo_count <= 0;
    else if (fifo_wr_en) fifo_count <= fifo_count + 1;
  end

  always @(posedge wr_clk) begin
    if (f0_wr_en) cnt2 <= cnt2 + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = v + 8'd1;
    end
  endtask

  task automatic wait_level(input logic lvl, input int budget, output int cyc);
    cyc = 0;
    while (fifo_wr_en !== lvl && cyc < budget) begin
      @(negedge wr_clk);
      cyc++;
    end
  endtask

  // scoreboard: every write popped and compared against the expected queue
  always @(negedge wr_clk) begin : mon_main
    logic [7:0] d;
    if (fifo_wr_en === 1'b1) begin
      wr_total++;
      check("overflow", fifo_count < 256, 1);
      check("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        check("wr_data", fifo_wr_data, d);
      end
    end
  end

  always @(negedge wr_clk) begin : mon_f0
    logic [7:0] d;
    if (f0_wr_en === 1'b1) begin
      check("f0_wr_expected", exp2_q.size() > 0, 1);
      if (exp2_q.size() > 0) begin
        d = exp2_q.pop_front();
        check("f0_wr_data", f0_wr_data, d);
      end
    end
  end

  task automatic check_bursts(input string tag);
`ifdef FIFO_WR_STAT_EN
    check(tag, burst_cnt, exp_bursts);
`endif
  endtask

  // Drain the FIFO, expect n writes 00.. when empty is raised, then follow DONE back to IDLE.
  task automatic run_burst(input string tag, input int n);
    int cyc;
    int start_total;
    drain = 1'b1;
    @(negedge wr_clk);
    drain = 1'b0;
    af_at = n - 1;
    push_seq(8'h00, n);
    start_total = wr_total;
    empty_ovr = 1'b1;
    wait_level(1'b1, 40, cyc);
    check({tag, "_start"}, cyc < 40, 1);
    wait_level(1'b0, n + 10, cyc);
    check({tag, "_stop"}, cyc < n + 10, 1);
    check({tag, "_writes"}, wr_total - start_total, n);
    check({tag, "_queue"}, exp_q.size(), 0);
    check({tag, "_done"}, fsm_state, S_DONE);
    exp_bursts++;
    @(negedge wr_clk);
    check({tag, "_idle"}, fsm_state, S_IDLE);
    check_bursts({tag, "_burst_cnt"});
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int cyc;
    int bad;
    logic [7:0] v;

    // reset state
    drain = 1'b1;
    #1 sys_rst_n = 1'b0;
    repeat (3) @(negedge wr_clk);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 8'h00);
    check("rst_state", fsm_state, S_IDLE);
    check("rst_f0_data", f0_wr_data, 8'hF0);
    check("rst_f0_wr_en", f0_wr_en, 0);
    check_bursts("rst_burst_cnt");
    drain = 1'b0;

    // reset release with empty: 2 sync + 10 settle + 1 cycles, then 256 writes 00..FF
    push_seq(8'h00, 256);
    af_at = 255;
    empty_ovr_en = 1'b0;
    sys_rst_n = 1'b1;
    wait_level(1'b1, 50, cyc);
    check("first_wr_latency", cyc, 13);
    check("first_wr_data", fifo_wr_data, 8'h00);
    wait_level(1'b0, 300, cyc);
    check("burst256_stop", cyc < 300, 1);
    check("burst256_writes", wr_total, 256);
    check("burst256_fifo_count", fifo_count, 256);
    check("burst256_queue", exp_q.size(), 0);
    check("burst256_done", fsm_state, S_DONE);
    exp_bursts = 1;
    @(negedge wr_clk);
    check("burst256_idle", fsm_state, S_IDLE);
    check("burst256_reload", fifo_wr_data, 8'h00);
    check_bursts("burst256_burst_cnt");

    // DATA_START=F0 instance, 20-word burst wrapping through FF
    v = 8'hF0;
    for (int i = 0; i < 20; i++) begin
      exp2_q.push_back(v);
      v = v + 8'd1;
    end
    empty2 = 1'b1;
    cyc = 0;
    while (f0_wr_en !== 1'b1 && cyc < 40) begin
      @(negedge wr_clk);
      cyc++;
    end
    check("f0_latency", cyc, 6);
    cyc = 0;
    while (f0_wr_en !== 1'b0 && cyc < 40) begin
      @(negedge wr_clk);
      cyc++;
    end
    check("f0_stop", cyc < 40, 1);
    check("f0_writes", cnt2, 20);
    check("f0_queue", exp2_q.size(), 0);
    empty2 = 1'b0;
    @(negedge wr_clk);
    check("f0_reload", f0_wr_data, 8'hF0);
`ifdef FIFO_WR_STAT_EN
    check("f0_burst_cnt", f0_burst_cnt, 1);
`endif

    // stale empty: empty held high after DONE must not restart
    empty_ovr_en = 1'b1;
    empty_ovr = 1'b0;
    run_burst("stale_a", 5);
    bad = 0;
    repeat (40) begin
      @(negedge wr_clk);
      if (fifo_wr_en !== 1'b0 || fsm_state !== S_IDLE) bad++;
    end
    check("stale_empty_hold", bad, 0);
    empty_ovr = 1'b0;
    repeat (4) @(negedge wr_clk);
    run_burst("stale_b", 5);

    // wr_rst_busy pulse mid-burst
    empty_ovr = 1'b0;
    repeat (4) @(negedge wr_clk);
    drain = 1'b1;
    @(negedge wr_clk);
    drain = 1'b0;
    af_at = 1000;
    push_seq(8'h00, 100);
    empty_ovr = 1'b1;
    wait_level(1'b1, 40, cyc);
    check("abort_start", cyc < 40, 1);
    repeat (10) @(negedge wr_clk);
    wr_rst_busy = 1'b1;
    empty_ovr = 1'b0;
    @(negedge wr_clk);
    check("abort_wr_en", fifo_wr_en, 0);
    check("abort_state", fsm_state, S_IDLE);
    check("abort_reload", fifo_wr_data, 8'h00);
    repeat (2) @(negedge wr_clk);
    wr_rst_busy = 1'b0;
    exp_q.delete();
    check_bursts("abort_burst_cnt");
    bad = 0;
    repeat (20) begin
      @(negedge wr_clk);
      if (fifo_wr_en !== 1'b0 || fsm_state !== S_IDLE) bad++;
    end
    check("abort_no_restart", bad, 0);
    run_burst("after_abort", 3);

    // sys_rst_n mid-burst: asynchronous abort, then restart on an empty that is still high
    empty_ovr = 1'b0;
    repeat (4) @(negedge wr_clk);
    drain = 1'b1;
    @(negedge wr_clk);
    drain = 1'b0;
    af_at = 1000;
    push_seq(8'h00, 100);
    empty_ovr = 1'b1;
    wait_level(1'b1, 40, cyc);
    check("rstmid_start", cyc < 40, 1);
    repeat (5) @(negedge wr_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("rstmid_wr_en", fifo_wr_en, 0);
    check("rstmid_wr_data", fifo_wr_data, 8'h00);
    check("rstmid_state", fsm_state, S_IDLE);
    exp_bursts = 0;
    check_bursts("rstmid_burst_cnt");
    exp_q.delete();
    drain = 1'b1;
    @(negedge wr_clk);
    drain = 1'b0;
    af_at = 2;
    push_seq(8'h00, 3);
    sys_rst_n = 1'b1;
    wait_level(1'b1, 50, cyc);
    check("rstrel_latency", cyc, 13);
    wait_level(1'b0, 20, cyc);
    check("rstrel_stop", cyc < 20, 1);
    check("rstrel_queue", exp_q.size(), 0);
    exp_bursts = 1;
    @(negedge wr_clk);
    check_bursts("rstrel_burst_cnt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
